hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1-3: number of consecutive cycles IF/ID and ID/EX are flushed per redirect.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination register of instruction in EX.
REQ-007 ex_mem_read  in  1  EX instruction is a load.
REQ-008 ex_branch_taken, ex_jalr  in  1 each  control redirect resolved in EX.
REQ-009 imem_ready  in  1  instruction memory returns valid data this cycle.
REQ-010 pc_write  out  1  PC register may update.
REQ-011 if_id_write  out  1  IF/ID register may load.
REQ-012 if_id_flush  out  1  IF/ID register loads zero (NOP).
REQ-013 id_ex_bubble  out  1  ID/EX register loads zero (NOP).

Function
REQ-014 FSM states: RUN, LU_STALL, FLUSH, IMEM_WAIT; outputs combinational from state and inputs.
REQ-015 redirect = ex_branch_taken | ex_jalr; load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
REQ-016 Priority in every state: redirect > load_use > !imem_ready.
REQ-017 Redirect in any state: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1 that cycle; next state FLUSH with flush_cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-018 FLUSH: pc_write=1, if_id_flush=1, id_ex_bubble=1; load_use and imem_ready ignored; flush_cnt decrements each cycle; RUN when flush_cnt reaches 0 at edge (count 1 -> RUN).
REQ-019 RUN, load_use, no redirect: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1; next state LU_STALL (exactly one bubble).
REQ-020 LU_STALL: normal outputs (pc_write=1, if_id_write=1, flush/bubble=0); load_use detection masked; next RUN unless redirect or !imem_ready.
REQ-021 RUN or LU_STALL with !imem_ready, no redirect/load_use: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=0; next IMEM_WAIT.
REQ-022 IMEM_WAIT: same outputs as REQ-021 while !imem_ready; when imem_ready=1 normal outputs and next RUN; load_use ignored (ID holds NOP).
REQ-023 RUN with no hazard: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0; stay RUN.
REQ-024 Redirect coinciding with load_use or !imem_ready: redirect outputs only; no stall.
REQ-025 flush_cnt is 2 bits; never wraps below 0.

Reset
REQ-026 reset=1 at edge: state=RUN, flush_cnt=0, perf counters=0.
REQ-027 While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1 regardless of inputs.
REQ-028 Reset mid-FLUSH/IMEM_WAIT/LU_STALL aborts it; first cycle after release behaves as RUN.

Configuration
REQ-029 Macro HAZARD_PERF_EN defined: add outputs stall_cycles[31:0] (cycles with pc_write=0 outside reset) and flush_cycles[31:0] (cycles with if_id_flush=1 due to redirect/FLUSH); both saturate at 0xFFFFFFFF.
REQ-030 HAZARD_PERF_EN undefined: ports and counter logic absent; all other behaviour identical.

Structure
REQ-031 Shared package hazard_pkg holds state enum (hazard_state_t) and REG_ADDR_W=5.
REQ-032 Perf counters in sub-module hazard_perf_cnt (one saturating 32-bit counter, enable input), instantiated twice under HAZARD_PERF_EN.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (inputs unchanged) normal outputs, state RUN after.
REQ-034 ex_jalr=1 one cycle, FLUSH_CYCLES=2 -> if_id_flush=id_ex_bubble=1 for 2 cycles, then normal.
REQ-035 Redirect and load_use same cycle -> pc_write=1, if_id_flush=1, no stall following.
REQ-036 imem_ready=0 for 3 cycles -> pc_write=0, if_id_flush=1 for 3 cycles; resumes on imem_ready=1.
REQ-037 reset asserted in second FLUSH cycle -> REQ-027 outputs; after release, RUN outputs with no residual flush.
REQ-038 With HAZARD_PERF_EN: sequence of REQ-033 plus REQ-036 -> stall_cycles=4; REQ-034 -> flush_cycles=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int FLUSH_CNT_W = 2;
  localparam int PERF_W      = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    FLUSH     = 2'd2,
    IMEM_WAIT = 2'd3
  } hazard_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } hazard_ctl_t;

  localparam hazard_ctl_t CTL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam hazard_ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1};
  localparam hazard_ctl_t CTL_LU_STALL = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam hazard_ctl_t CTL_IMEM     = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam hazard_ctl_t CTL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1};

  // A load in EX whose (non-x0) destination is read by the ID instruction.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic                  use_rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs2
  );
    logic rd_nz;
    rd_nz = (rd != {REG_ADDR_W{1'b0}});
    return mem_read & rd_nz & ((use_rs1 & (rd == rs1)) | (use_rs2 & (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// One saturating 32-bit event counter with a count enable.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en_i,
  output logic [PERF_W-1:0] count_o
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  // Increment when enabled, holding at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {PERF_W{1'b1}})) begin
      count_d = count_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {PERF_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, imem wait.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_jalr,
  input  logic                  imem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_cycles
`endif
);

  localparam logic                   MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE     = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};

  hazard_state_t           state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  hazard_ctl_t             ctl_s;
  logic                    redirect_s;
  logic                    load_use_s;

  assign redirect_s = ex_branch_taken | ex_jalr;
  assign load_use_s = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

  // Next state and control outputs; reset forces safe outputs, redirect beats all.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ctl_s       = CTL_NORMAL;
    if (reset) begin
      ctl_s       = CTL_RESET;
      state_d     = RUN;
      flush_cnt_d = {FLUSH_CNT_W{1'b0}};
    end else if (redirect_s) begin
      ctl_s = CTL_REDIRECT;
      if (MULTI_FLUSH) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_INIT;
      end else begin
        state_d     = RUN;
        flush_cnt_d = {FLUSH_CNT_W{1'b0}};
      end
    end else begin
      case (state_q)
        RUN: begin
          if (load_use_s) begin
            ctl_s   = CTL_LU_STALL;
            state_d = LU_STALL;
          end else if (!imem_ready) begin
            ctl_s   = CTL_IMEM;
            state_d = IMEM_WAIT;
          end else begin
            ctl_s   = CTL_NORMAL;
            state_d = RUN;
          end
        end
        // The stalled load has moved on, so a second bubble is never inserted.
        LU_STALL: begin
          if (!imem_ready) begin
            ctl_s   = CTL_IMEM;
            state_d = IMEM_WAIT;
          end else begin
            ctl_s   = CTL_NORMAL;
            state_d = RUN;
          end
        end
        FLUSH: begin
          ctl_s = CTL_REDIRECT;
          if (flush_cnt_q > CNT_ONE) begin
            flush_cnt_d = flush_cnt_q - CNT_ONE;
            state_d     = FLUSH;
          end else begin
            flush_cnt_d = {FLUSH_CNT_W{1'b0}};
            state_d     = RUN;
          end
        end
        IMEM_WAIT: begin
          if (!imem_ready) begin
            ctl_s   = CTL_IMEM;
            state_d = IMEM_WAIT;
          end else begin
            ctl_s   = CTL_NORMAL;
            state_d = RUN;
          end
        end
        default: begin
          ctl_s       = CTL_NORMAL;
          state_d     = RUN;
          flush_cnt_d = {FLUSH_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and flush-count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= {FLUSH_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_write     = ctl_s.pc_write;
  assign if_id_write  = ctl_s.if_id_write;
  assign if_id_flush  = ctl_s.if_id_flush;
  assign id_ex_bubble = ctl_s.id_ex_bubble;

`ifdef HAZARD_PERF_EN
  logic stall_evt_s;
  logic flush_evt_s;

  // Imem-wait flushes are excluded: only redirect-driven squashes count.
  assign stall_evt_s = !reset && !ctl_s.pc_write;
  assign flush_evt_s = !reset && (redirect_s || (state_q == FLUSH));

  hazard_perf_cnt u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .en_i    (stall_evt_s),
    .count_o (stall_cycles)
  );

  hazard_perf_cnt u_flush_cnt (
    .clock   (clock),
    .reset   (reset),
    .en_i    (flush_evt_s),
    .count_o (flush_cycles)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2) with a per-cycle reference model.
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_jalr = 1'b0;
  logic       imem_ready = 1'b1;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_jalr         (ex_jalr),
    .imem_ready      (imem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Model history: flush cycles still owed, and whether load-use is masked this cycle.
  int          m_flush_left = 0;
  bit          m_masked = 1'b0;
  bit          m_redirect, m_lu;
  logic [3:0]  m_exp;
  logic [31:0] m_stall = 32'd0, m_flushc = 32'd0;
  bit          m_cnt_valid = 1'b0;

  always @(negedge clock) begin
    m_redirect = ex_branch_taken | ex_jalr;
    m_lu = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    if (reset) begin
      m_exp = 4'b0011;
    end else if (m_redirect || m_flush_left > 0) begin
      m_exp = 4'b1111;
    end else if (m_lu && !m_masked) begin
      m_exp = 4'b0001;
    end else if (!imem_ready) begin
      m_exp = 4'b0110;
    end else begin
      m_exp = 4'b1100;
    end
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} !== m_exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%b expected=%b", $time,
               {pc_write, if_id_write, if_id_flush, id_ex_bubble}, m_exp);
    end
`ifdef HAZARD_PERF_EN
    if (m_cnt_valid) begin
      checks++;
      if (stall_cycles !== m_stall || flush_cycles !== m_flushc) begin
        errors++;
        $display("FAIL model_perf t=%0t got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 $time, stall_cycles, flush_cycles, m_stall, m_flushc);
      end
    end
`endif
    if (reset) begin
      m_flush_left = 0;
      m_masked     = 1'b0;
      m_stall      = 32'd0;
      m_flushc     = 32'd0;
      m_cnt_valid  = 1'b1;
    end else begin
      if (m_redirect) m_flush_left = FC - 1;
      else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
      m_masked = (m_exp == 4'b0001) || (m_exp == 4'b0110);
      if (!m_exp[3]) m_stall = m_stall + 32'd1;
      if (m_exp == 4'b1111) m_flushc = m_flushc + 32'd1;
    end
  end

  // Spend one cycle with the current inputs and check a hand-computed output vector.
  task automatic expect_out(input string name, input logic [3:0] exp);
    @(negedge clock);
    #1;
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name,
               {pc_write, if_id_write, if_id_flush, id_ex_bubble}, exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1'b1;
    ex_rd = rd; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  task automatic idle();
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_branch_taken = 1'b0; ex_jalr = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Reset dominates every input
    ex_jalr = 1'b1; imem_ready = 1'b0; set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    expect_out("reset_dominates", 4'b0011);
    idle();
    expect_out("reset_idle", 4'b0011);
    reset = 1'b0;
    expect_out("run_normal", 4'b1100);

    // Single load-use bubble, then release with unchanged inputs
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    expect_out("lu_stall", 4'b0001);
    expect_out("lu_release", 4'b1100);
    idle();
    expect_out("lu_clear", 4'b1100);

    // Instruction memory wait for three cycles
    imem_ready = 1'b0;
    expect_out("imem_wait1", 4'b0110);
    expect_out("imem_wait2", 4'b0110);
    expect_out("imem_wait3", 4'b0110);
    imem_ready = 1'b1;
    expect_out("imem_resume", 4'b1100);
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL perf_stall4: got %0d expected 4", stall_cycles);
    end
`endif

    // Load-use qualification corners
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("lu_rd_zero", 4'b1100);
    set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
    expect_out("lu_rs2_unused", 4'b1100);
    set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    expect_out("lu_rs2", 4'b0001);
    expect_out("lu_masked", 4'b1100);
    expect_out("lu_rearm", 4'b0001);
    imem_ready = 1'b0;
    expect_out("lustall_imem", 4'b0110);
    expect_out("imemwait_lu_ignored", 4'b0110);
    imem_ready = 1'b1;
    expect_out("imemwait_ready", 4'b1100);
    expect_out("run_lu_again", 4'b0001);
    idle();
    expect_out("lu_stall_normal", 4'b1100);

    reset = 1'b1;
    expect_out("reset_again", 4'b0011);
    reset = 1'b0;

    // Jalr flushes for FLUSH_CYCLES cycles
    ex_jalr = 1'b1;
    expect_out("jalr", 4'b1111);
    idle();
    expect_out("flush2", 4'b1111);
    expect_out("after_flush", 4'b1100);
`ifdef HAZARD_PERF_EN
    checks++;
    if (flush_cycles !== 32'd2) begin
      errors++;
      $display("FAIL perf_flush2: got %0d expected 2", flush_cycles);
    end
`endif

    // Redirect beats load-use; FLUSH ignores load-use
    ex_branch_taken = 1'b1; set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    expect_out("br_lu", 4'b1111);
    ex_branch_taken = 1'b0;
    expect_out("flush_ignores_lu", 4'b1111);
    idle();
    expect_out("br_lu_no_stall", 4'b1100);

    // Redirect beats imem wait; FLUSH ignores imem_ready
    ex_jalr = 1'b1; imem_ready = 1'b0;
    expect_out("br_imem", 4'b1111);
    ex_jalr = 1'b0;
    expect_out("flush_ignores_imem", 4'b1111);
    expect_out("imem_after_flush", 4'b0110);
    imem_ready = 1'b1;
    expect_out("imem_after_flush_resume", 4'b1100);

    // Redirect from LU_STALL and from IMEM_WAIT
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    expect_out("lu_before_br", 4'b0001);
    ex_branch_taken = 1'b1;
    expect_out("br_in_lustall", 4'b1111);
    idle();
    expect_out("br_in_lustall_flush", 4'b1111);
    expect_out("br_in_lustall_done", 4'b1100);
    imem_ready = 1'b0;
    expect_out("imem_before_br", 4'b0110);
    ex_branch_taken = 1'b1;
    expect_out("br_in_imemwait", 4'b1111);
    ex_branch_taken = 1'b0;
    expect_out("br_in_imemwait_flush", 4'b1111);
    imem_ready = 1'b1;
    expect_out("br_in_imemwait_done", 4'b1100);

    // Back-to-back redirects restart the flush window
    ex_jalr = 1'b1;
    expect_out("jalr_a", 4'b1111);
    expect_out("jalr_b", 4'b1111);
    idle();
    expect_out("jalr_b_flush", 4'b1111);
    expect_out("jalr_b_done", 4'b1100);

    // Reset in the second flush cycle aborts it
    ex_jalr = 1'b1;
    expect_out("jalr_pre_reset", 4'b1111);
    idle();
    reset = 1'b1;
    expect_out("reset_mid_flush", 4'b0011);
    reset = 1'b0;
    expect_out("no_residual_flush", 4'b1100);
    expect_out("run_steady", 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
